axi4lite_flash_prefetch: RTL and testbench

Parametrised read-buffering front end for `axi4lite_flash`. Sits between the CPU-side AXI4-lite bus and the flash controller and keeps a small fully-associative buffer of recently read words. After each demand miss it prefetches the next sequential word, so straight-line instruction fetch from flash mostly hits with one-cycle latency. Writes are answered locally with SLVERR and never reach the flash.

---
 rtl/axi4lite_flash_prefetch.sv | 191 +++++++++++++++++++
 tb/tb_axi4lite_flash_prefetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_flash_prefetch.sv
// axi4lite_flash_prefetch: fully-associative read buffer with sequential prefetch in front of axi4lite_flash
module axi4lite_flash_prefetch #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 64,
  parameter int LINES = 4,
  parameter int PREFETCH = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    invalidate,
  input  logic [ADDR_WIDTH-1:0]   bus_awaddr,
  input  logic                    bus_awvalid,
  output logic                    bus_awready,
  input  logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH/8-1:0] bus_wstrb,
  input  logic                    bus_wvalid,
  output logic                    bus_wready,
  output logic [1:0]              bus_bresp,
  output logic                    bus_bvalid,
  input  logic                    bus_bready,
  input  logic [ADDR_WIDTH-1:0]   bus_araddr,
  input  logic                    bus_arvalid,
  output logic                    bus_arready,
  output logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic [1:0]              bus_rresp,
  output logic                    bus_rvalid,
  input  logic                    bus_rready,
  output logic [ADDR_WIDTH-1:0]   flash_awaddr,
  output logic                    flash_awvalid,
  input  logic                    flash_awready,
  output logic [DATA_WIDTH-1:0]   flash_wdata,
  output logic [DATA_WIDTH/8-1:0] flash_wstrb,
  output logic                    flash_wvalid,
  input  logic                    flash_wready,
  input  logic [1:0]              flash_bresp,
  input  logic                    flash_bvalid,
  output logic                    flash_bready,
  output logic [ADDR_WIDTH-1:0]   flash_araddr,
  output logic                    flash_arvalid,
  input  logic                    flash_arready,
  input  logic [DATA_WIDTH-1:0]   flash_rdata,
  input  logic [1:0]              flash_rresp,
  input  logic                    flash_rvalid,
  output logic                    flash_rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW = $clog2(LINES);
  typedef enum logic [2:0] {IDLE, MISS_AR, MISS_R, RESP, PF_AR, PF_R} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] tag_q [LINES];
  logic [ADDR_WIDTH-1:0] tag_d [LINES];
  logic [DATA_WIDTH-1:0] line_q [LINES];
  logic [DATA_WIDTH-1:0] line_d [LINES];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pf_addr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, hit_data;
  logic [1:0] rresp_q, rresp_d, bresp_q, bresp_d;
  logic miss_q, miss_d, kill_q, kill_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic flash_arvalid_q, flash_arvalid_d, flash_rready_q, flash_rready_d;
  logic aw_q, aw_d, w_q, w_d, bvalid_q, bvalid_d;
  logic hit, pf_hit, f_hs, fill, aw_hs, w_hs;
  logic unused;
  assign unused = ^{bus_awaddr, bus_wdata, bus_wstrb, flash_awready, flash_wready, flash_bresp, flash_bvalid};
  assign pf_addr = addr_q + ADDR_WIDTH'(BYTES);
  assign f_hs = flash_rvalid && flash_rready_q;
  // a fill is dropped if invalidate was seen at any point of the flash transaction
  assign fill = f_hs && flash_rresp == 2'b00 && !kill_q && !invalidate;
  always_comb begin
    hit = 1'b0;
    pf_hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && tag_q[i] == bus_araddr) begin
        hit = 1'b1;
        hit_data = line_q[i];
      end
      pf_hit |= valid_q[i] && tag_q[i] == pf_addr;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    miss_d = miss_q;
    tag_d = tag_q;
    line_d = line_q;
    ptr_d = fill ? ptr_q + 1'b1 : ptr_q;
    valid_d = invalidate ? '0 : valid_q;
    kill_d = (state_q == IDLE || state_q == RESP) ? invalidate : kill_q || invalidate;
    if (fill) begin
      valid_d[ptr_q] = 1'b1;
      tag_d[ptr_q] = addr_q;
      line_d[ptr_q] = flash_rdata;
    end
    case (state_q)
      IDLE: if (bus_arvalid && arready_q) begin
        addr_d = bus_araddr;
        miss_d = !hit;
        state_d = hit ? RESP : MISS_AR;
        if (hit) begin
          rdata_d = hit_data;
          rresp_d = 2'b00;
        end
      end
      MISS_AR, PF_AR: if (flash_arready) state_d = state_q == MISS_AR ? MISS_R : PF_R;
      MISS_R: if (f_hs) begin
        rdata_d = flash_rdata;
        rresp_d = flash_rresp;
        state_d = RESP;
      end
      PF_R: if (f_hs) state_d = IDLE;
      RESP: if (bus_rready) begin
        state_d = (miss_q && rresp_q == 2'b00 && PREFETCH != 0 && !pf_hit) ? PF_AR : IDLE;
        if (state_d == PF_AR) addr_d = pf_addr;
      end
      default: state_d = IDLE;
    endcase
    arready_d = state_d == IDLE;
    rvalid_d = state_d == RESP;
    flash_arvalid_d = state_d == MISS_AR || state_d == PF_AR;
    flash_rready_d = state_d == MISS_R || state_d == PF_R;
  end
  assign bus_awready = !aw_q && !bvalid_q;
  assign bus_wready = !w_q && !bvalid_q;
  assign aw_hs = bus_awvalid && bus_awready;
  assign w_hs = bus_wvalid && bus_wready;
  always_comb begin
    bvalid_d = bvalid_q ? !bus_bready : (aw_q || aw_hs) && (w_q || w_hs);
    aw_d = !bvalid_d && (aw_q || aw_hs);
    w_d = !bvalid_d && (w_q || w_hs);
    bresp_d = bvalid_d ? 2'b10 : bresp_q;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      valid_q <= '0;
      tag_q <= '{default: '0};
      line_q <= '{default: '0};
      ptr_q <= '0;
      addr_q <= '0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      miss_q <= 1'b0;
      kill_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      flash_arvalid_q <= 1'b0;
      flash_rready_q <= 1'b0;
      aw_q <= 1'b0;
      w_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      line_q <= line_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      miss_q <= miss_d;
      kill_q <= kill_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      flash_arvalid_q <= flash_arvalid_d;
      flash_rready_q <= flash_rready_d;
      aw_q <= aw_d;
      w_q <= w_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
    end
  assign bus_arready = arready_q;
  assign bus_rvalid = rvalid_q;
  assign bus_rdata = rdata_q;
  assign bus_rresp = rresp_q;
  assign bus_bvalid = bvalid_q;
  assign bus_bresp = bresp_q;
  assign flash_araddr = addr_q;
  assign flash_arvalid = flash_arvalid_q;
  assign flash_rready = flash_rready_q;
  assign flash_awaddr = '0;
  assign flash_awvalid = 1'b0;
  assign flash_wdata = '0;
  assign flash_wstrb = '0;
  assign flash_wvalid = 1'b0;
  assign flash_bready = 1'b1;
endmodule

// File: tb/tb_axi4lite_flash_prefetch.sv
// tb_axi4lite_flash_prefetch: scoreboard bench with a pattern flash mock; instance 0 prefetches, instance 1 does not
module tb_axi4lite_flash_prefetch;
  localparam logic [23:0] ERR_A = 24'hEEEEEE;
  typedef struct { int d; logic [63:0] data; logic [1:0] resp; } exp_t;
  logic aclk = 1'b0;
  logic aresetn;
  logic invalidate [2];
  logic bus_awvalid, bus_wvalid;
  logic bus_awready [2];
  logic bus_wready [2];
  logic [1:0] bus_bresp [2];
  logic bus_bvalid [2];
  logic [23:0] bus_araddr [2];
  logic bus_arvalid [2];
  logic bus_arready [2];
  logic [63:0] bus_rdata [2];
  logic [1:0] bus_rresp [2];
  logic bus_rvalid [2];
  logic [23:0] f_awaddr [2];
  logic [63:0] f_wdata [2];
  logic [7:0] f_wstrb [2];
  logic flash_awvalid [2];
  logic flash_wvalid [2];
  logic f_bready [2];
  logic [23:0] flash_araddr [2];
  logic flash_arvalid [2];
  logic flash_arready [2];
  logic [63:0] flash_rdata [2];
  logic [1:0] flash_rresp [2];
  logic flash_rready [2];
  logic f_busy [2];
  logic f_rvalid [2];
  logic [23:0] f_addr [2];
  int f_cnt [2];
  int ar_cnt [2];
  int wr_leak [2];
  logic [23:0] last_ar [2];
  exp_t exp_q [$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  always #5 aclk = ~aclk;
  function automatic logic [63:0] pat(input logic [23:0] a);
    logic [23:0] b;
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      b = a + 24'(k);
      pat[k*8 +: 8] = b[7:0] ^ b[15:8] ^ b[23:16];
    end
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi4lite_flash_prefetch #(.PREFETCH(g == 0 ? 1 : 0)) dut (
      .aclk(aclk), .aresetn(aresetn), .invalidate(invalidate[g]),
      .bus_awaddr(24'h414141), .bus_awvalid(g == 0 ? bus_awvalid : 1'b0), .bus_awready(bus_awready[g]),
      .bus_wdata(64'h0123456789abcdef), .bus_wstrb(8'hff), .bus_wvalid(g == 0 ? bus_wvalid : 1'b0),
      .bus_wready(bus_wready[g]), .bus_bresp(bus_bresp[g]), .bus_bvalid(bus_bvalid[g]), .bus_bready(1'b1),
      .bus_araddr(bus_araddr[g]), .bus_arvalid(bus_arvalid[g]), .bus_arready(bus_arready[g]),
      .bus_rdata(bus_rdata[g]), .bus_rresp(bus_rresp[g]), .bus_rvalid(bus_rvalid[g]), .bus_rready(1'b1),
      .flash_awaddr(f_awaddr[g]), .flash_awvalid(flash_awvalid[g]), .flash_awready(1'b1),
      .flash_wdata(f_wdata[g]), .flash_wstrb(f_wstrb[g]), .flash_wvalid(flash_wvalid[g]), .flash_wready(1'b1),
      .flash_bresp(2'b00), .flash_bvalid(1'b0), .flash_bready(f_bready[g]),
      .flash_araddr(flash_araddr[g]), .flash_arvalid(flash_arvalid[g]), .flash_arready(flash_arready[g]),
      .flash_rdata(flash_rdata[g]), .flash_rresp(flash_rresp[g]), .flash_rvalid(f_rvalid[g]),
      .flash_rready(flash_rready[g]));
    assign flash_arready[g] = !f_busy[g];
    assign flash_rdata[g] = pat(f_addr[g]);
    assign flash_rresp[g] = f_addr[g] == ERR_A ? 2'b10 : 2'b00;
  end
  always @(posedge aclk)
    for (int k = 0; k < 2; k++)
      if (!aresetn) begin
        f_busy[k] <= 1'b0;
        f_rvalid[k] <= 1'b0;
        f_cnt[k] <= 0;
        f_addr[k] <= '0;
        ar_cnt[k] <= 0;
        wr_leak[k] <= 0;
        last_ar[k] <= '0;
      end else begin
        if (flash_arvalid[k] && !f_busy[k]) begin
          f_busy[k] <= 1'b1;
          f_cnt[k] <= 3;
          f_addr[k] <= flash_araddr[k];
          last_ar[k] <= flash_araddr[k];
          ar_cnt[k] <= ar_cnt[k] + 1;
        end else if (f_busy[k] && !f_rvalid[k]) begin
          if (f_cnt[k] == 0) f_rvalid[k] <= 1'b1;
          else f_cnt[k] <= f_cnt[k] - 1;
        end else if (f_rvalid[k] && flash_rready[k]) begin
          f_rvalid[k] <= 1'b0;
          f_busy[k] <= 1'b0;
        end
        if (flash_awvalid[k] || flash_wvalid[k]) wr_leak[k] <= wr_leak[k] + 1;
      end
  always @(negedge aclk)
    for (int k = 0; k < 2; k++)
      if (aresetn && bus_rvalid[k]) begin
        if (exp_q.size() == 0) check("r_unexpected", 64'(k), 64'hff);
        else begin
          e = exp_q.pop_front();
          check("r_dut", 64'(k), 64'(e.d));
          check("rdata", bus_rdata[k], e.data);
          check("rresp", 64'(bus_rresp[k]), 64'(e.resp));
        end
      end
  task automatic rd(input int d, input logic [23:0] a, output int wn, output int lat);
    exp_q.push_back('{d, pat(a), a == ERR_A ? 2'b10 : 2'b00});
    bus_araddr[d] = a;
    bus_arvalid[d] = 1'b1;
    wn = 0;
    while (!bus_arready[d] && wn < 100) begin @(negedge aclk); wn++; end
    if (wn >= 100) check("ar_timeout", 64'(wn), 0);
    @(negedge aclk);
    bus_arvalid[d] = 1'b0;
    lat = 1;
    while (!bus_rvalid[d] && lat < 100) begin @(negedge aclk); lat++; end
    if (lat >= 100) check("r_timeout", 64'(lat), 0);
  endtask
  task automatic wait_idle(input int d);
    int n = 0;
    while (!bus_arready[d] && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) check("idle_timeout", 64'(n), 0);
  endtask
  task automatic pulse_inv(input int d);
    invalidate[d] = 1'b1;
    @(negedge aclk);
    invalidate[d] = 1'b0;
  endtask
  task automatic wr(input int aw_dly, input int w_dly);
    int na = 0;
    int nw = 0;
    fork
      begin
        repeat (aw_dly) @(negedge aclk);
        bus_awvalid = 1'b1;
        while (!bus_awready[0] && na < 50) begin @(negedge aclk); na++; end
        @(negedge aclk);
        bus_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge aclk);
        bus_wvalid = 1'b1;
        while (!bus_wready[0] && nw < 50) begin @(negedge aclk); nw++; end
        @(negedge aclk);
        bus_wvalid = 1'b0;
      end
    join
    check("aw_wait", 64'(na), 0);
    check("w_wait", 64'(nw), 0);
    check("bvalid", 64'(bus_bvalid[0]), 1);
    check("bresp", 64'(bus_bresp[0]), 2);
    check("awready_in_b", 64'(bus_awready[0]), 0);
    check("wready_in_b", 64'(bus_wready[0]), 0);
    @(negedge aclk);
    check("bvalid_clear", 64'(bus_bvalid[0]), 0);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int wn, lat, c, n;
    aresetn = 1'b0;
    bus_awvalid = 1'b0;
    bus_wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      invalidate[k] = 1'b0;
      bus_arvalid[k] = 1'b0;
      bus_araddr[k] = '0;
    end
    repeat (3) @(negedge aclk);
    check("rst_arready", 64'(bus_arready[0]), 0);
    check("rst_rvalid", 64'(bus_rvalid[0]), 0);
    check("rst_bvalid", 64'(bus_bvalid[0]), 0);
    check("rst_awready", 64'(bus_awready[0]), 1);
    check("rst_wready", 64'(bus_wready[0]), 1);
    check("rst_f_arvalid", 64'(flash_arvalid[0]), 0);
    check("rst_f_rready", 64'(flash_rready[0]), 0);
    check("rst_f_bready", 64'(f_bready[0]), 1);
    check("rst_rdata", bus_rdata[0], 0);
    check("rst_resp", 64'({bus_rresp[0], bus_bresp[0]}), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("arready_after_rst", 64'(bus_arready[0]), 1);
    // cold miss, then the sequential prefetch, then a one-cycle hit
    rd(0, 24'hAABBCC, wn, lat);
    check("cold_ar_cnt", 64'(ar_cnt[0]), 1);
    check("cold_ar_addr", 64'(last_ar[0]), 64'hAABBCC);
    wait_idle(0);
    check("pf_ar_cnt", 64'(ar_cnt[0]), 2);
    check("pf_ar_addr", 64'(last_ar[0]), 64'hAABBD4);
    rd(0, 24'hAABBD4, wn, lat);
    check("hit_lat", 64'(lat), 1);
    check("hit_no_ar", 64'(ar_cnt[0]), 2);
    rd(0, 24'h000000, wn, lat);
    n = 0;
    while (ar_cnt[0] < 4 && n < 50) begin @(negedge aclk); n++; end
    check("pf_started", 64'(ar_cnt[0]), 4);
    check("ar_blocked", 64'(bus_arready[0]), 0);
    rd(0, 24'h000010, wn, lat);
    check("ar_waited", 64'(wn > 0), 1);
    check("blk_miss_addr", 64'(last_ar[0]), 64'h10);
    check("blk_miss_cnt", 64'(ar_cnt[0]), 5);
    wait_idle(0);
    pulse_inv(0);
    c = ar_cnt[0];
    rd(0, 24'hFFFFF8, wn, lat);
    wait_idle(0);
    check("wrap_pf_addr", 64'(last_ar[0]), 0);
    check("wrap_pf_cnt", 64'(ar_cnt[0]), 64'(c + 2));
    rd(0, 24'h000000, wn, lat);
    check("wrap_hit_lat", 64'(lat), 1);
    check("wrap_hit_no_ar", 64'(ar_cnt[0]), 64'(c + 2));
    // error responses are forwarded, never buffered, never prefetched past
    c = ar_cnt[0];
    rd(0, ERR_A, wn, lat);
    wait_idle(0);
    check("err_no_pf", 64'(ar_cnt[0]), 64'(c + 1));
    rd(0, ERR_A, wn, lat);
    wait_idle(0);
    check("err_not_filled", 64'(ar_cnt[0]), 64'(c + 2));
    c = ar_cnt[0];
    fork
      rd(0, 24'h123450, wn, lat);
      begin
        n = 0;
        while (ar_cnt[0] == c && n < 50) begin @(negedge aclk); n++; end
        pulse_inv(0);
      end
    join
    wait_idle(0);
    check("inflight_pf_cnt", 64'(ar_cnt[0]), 64'(c + 2));
    rd(0, 24'h123450, wn, lat);
    wait_idle(0);
    check("inflight_killed", 64'(ar_cnt[0]), 64'(c + 3));
    check("pf_skip_present", 64'(last_ar[0]), 64'h123450);
    fork wr(0, 0); rd(0, 24'h414100, wn, lat); join
    wait_idle(0);
    fork wr(0, 5); rd(0, 24'h414200, wn, lat); join
    wait_idle(0);
    fork wr(5, 0); rd(0, 24'h414300, wn, lat); join
    wait_idle(0);
    // round-robin eviction and invalidate without prefetch
    for (int i = 0; i < 5; i++) begin
      rd(1, 24'(i * 8), wn, lat);
      wait_idle(1);
    end
    check("np_fill_cnt", 64'(ar_cnt[1]), 5);
    rd(1, 24'h000008, wn, lat);
    check("np_hit_lat", 64'(lat), 1);
    rd(1, 24'h000000, wn, lat);
    wait_idle(1);
    check("np_evicted", 64'(ar_cnt[1]), 6);
    rd(1, 24'h000000, wn, lat);
    check("np_refill_hit", 64'(lat), 1);
    pulse_inv(1);
    rd(1, 24'h000000, wn, lat);
    wait_idle(1);
    check("np_inv_miss", 64'(ar_cnt[1]), 7);
    repeat (2) @(negedge aclk);
    check("sb_empty", 64'(exp_q.size()), 0);
    check("no_flash_writes", 64'(wr_leak[0] + wr_leak[1]), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
